// File: rtl/sram_1rw1r_ctrl.sv
// Host controller for a sky130 1RW+1R SRAM macro: maps two valid/ready request
// channels onto macro pins and returns read data through per-channel FWFT FIFOs.

module sram_rsp_fifo #(
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH      = 2,
    parameter int CNT_W      = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_push,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic                  i_pop,
    output logic                  o_valid,
    output logic [DATA_WIDTH-1:0] o_rdata,
    output logic [CNT_W-1:0]      o_count
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]      r_wptr;
    logic [PTR_W-1:0]      r_rptr;
    logic [CNT_W-1:0]      r_count;
    logic                  w_pop;

    assign w_pop   = i_pop && (r_count != '0);
    assign o_valid = (r_count != '0);
    // Output forced to zero when empty so rdata reads 0 out of reset.
    assign o_rdata = o_valid ? r_mem[r_rptr] : '0;
    assign o_count = r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (i_push) begin
                r_wptr <= r_wptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PTR_W'(1);
            end
            case ({i_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wptr] <= i_wdata;
        end
    end
endmodule

module sram_1rw1r_ctrl #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 8,
    parameter int NUM_WMASKS = 8,
    parameter int RSP_DEPTH  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  a_req_valid,
    output logic                  a_req_ready,
    input  logic                  a_req_we,
    input  logic [NUM_WMASKS-1:0] a_req_wmask,
    input  logic [ADDR_WIDTH-1:0] a_req_addr,
    input  logic [DATA_WIDTH-1:0] a_req_wdata,
    output logic                  a_rsp_valid,
    input  logic                  a_rsp_ready,
    output logic [DATA_WIDTH-1:0] a_rsp_rdata,
    input  logic                  b_req_valid,
    output logic                  b_req_ready,
    input  logic [ADDR_WIDTH-1:0] b_req_addr,
    output logic                  b_rsp_valid,
    input  logic                  b_rsp_ready,
    output logic [DATA_WIDTH-1:0] b_rsp_rdata,
    output logic                  csb0,
    output logic                  web0,
    output logic [NUM_WMASKS-1:0] wmask0,
    output logic [ADDR_WIDTH-1:0] addr0,
    output logic [DATA_WIDTH-1:0] din0,
    input  logic [DATA_WIDTH-1:0] dout0,
    output logic                  csb1,
    output logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] dout1
);
    localparam int CNT_W = $clog2(RSP_DEPTH + 1);
    localparam int USE_W = CNT_W + 1;

    logic             r_a_vld_p1;
    logic             r_b_vld_p1;
    logic [CNT_W-1:0] w_a_count;
    logic [CNT_W-1:0] w_b_count;
    logic [USE_W-1:0] w_a_used;
    logic [USE_W-1:0] w_b_used;
    logic             w_a_credit;
    logic             w_b_credit;
    logic             w_a_issue;
    logic             w_a_rd_issue;
    logic             w_a_wr_issue;
    logic             w_collide;
    logic             w_b_issue;

    // Credit covers entries already queued plus the read still in the macro;
    // a pop in this same cycle is deliberately not counted as free space.
    assign w_a_used   = USE_W'(w_a_count) + USE_W'(r_a_vld_p1);
    assign w_b_used   = USE_W'(w_b_count) + USE_W'(r_b_vld_p1);
    assign w_a_credit = (w_a_used < USE_W'(RSP_DEPTH));
    assign w_b_credit = (w_b_used < USE_W'(RSP_DEPTH));

    assign a_req_ready  = !rst && (a_req_we || w_a_credit);
    assign w_a_issue    = a_req_valid && a_req_ready;
    assign w_a_rd_issue = w_a_issue && !a_req_we;
    assign w_a_wr_issue = w_a_issue && a_req_we;

    // B would otherwise read the old word while port 0 writes the same address.
    assign w_collide   = w_a_wr_issue && (a_req_addr == b_req_addr);
    assign b_req_ready = !rst && w_b_credit && !w_collide;
    assign w_b_issue   = b_req_valid && b_req_ready;

    assign csb0   = !w_a_issue;
    assign web0   = rst || !a_req_we;
    assign wmask0 = a_req_wmask;
    assign addr0  = a_req_addr;
    assign din0   = a_req_wdata;
    assign csb1   = !w_b_issue;
    assign addr1  = b_req_addr;

    // Stage p1: one-deep inflight marker; macro data is captured on the next edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a_vld_p1 <= 1'b0;
            r_b_vld_p1 <= 1'b0;
        end else begin
            r_a_vld_p1 <= w_a_rd_issue;
            r_b_vld_p1 <= w_b_issue;
        end
    end

    sram_rsp_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (RSP_DEPTH),
        .CNT_W      (CNT_W)
    ) u_a_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (r_a_vld_p1),
        .i_wdata (dout0),
        .i_pop   (a_rsp_ready),
        .o_valid (a_rsp_valid),
        .o_rdata (a_rsp_rdata),
        .o_count (w_a_count)
    );

    sram_rsp_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (RSP_DEPTH),
        .CNT_W      (CNT_W)
    ) u_b_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (r_b_vld_p1),
        .i_wdata (dout1),
        .i_pop   (b_rsp_ready),
        .o_valid (b_rsp_valid),
        .o_rdata (b_rsp_rdata),
        .o_count (w_b_count)
    );
endmodule

// File: tb/tb_sram_1rw1r_ctrl.sv
// Bench for sram_1rw1r_ctrl: behavioural macro, directed scenarios and random
// traffic checked against a byte-masked reference memory and response queues.

module tb_sram_1rw1r_ctrl;
    localparam int DW = 64;
    localparam int AW = 8;
    localparam int NM = 8;
    localparam int DEPTH = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          a_req_valid, a_req_ready, a_req_we;
    logic [NM-1:0] a_req_wmask;
    logic [AW-1:0] a_req_addr;
    logic [DW-1:0] a_req_wdata;
    logic          a_rsp_valid, a_rsp_ready;
    logic [DW-1:0] a_rsp_rdata;
    logic          b_req_valid, b_req_ready;
    logic [AW-1:0] b_req_addr;
    logic          b_rsp_valid, b_rsp_ready;
    logic [DW-1:0] b_rsp_rdata;
    logic          csb0, web0, csb1;
    logic [NM-1:0] wmask0;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] din0, dout0, dout1;

    int n_checks = 0;
    int n_fail = 0;

    logic [DW-1:0] macro_mem [256];
    logic [DW-1:0] ref_mem [256];

    typedef struct {
        logic [DW-1:0] data;
        int            cyc;
    } rsp_t;

    always #5 clk = ~clk;

    sram_1rw1r_ctrl #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .NUM_WMASKS (NM),
        .RSP_DEPTH  (DEPTH)
    ) dut (
        .clk (clk), .rst (rst),
        .a_req_valid (a_req_valid), .a_req_ready (a_req_ready), .a_req_we (a_req_we),
        .a_req_wmask (a_req_wmask), .a_req_addr (a_req_addr), .a_req_wdata (a_req_wdata),
        .a_rsp_valid (a_rsp_valid), .a_rsp_ready (a_rsp_ready), .a_rsp_rdata (a_rsp_rdata),
        .b_req_valid (b_req_valid), .b_req_ready (b_req_ready), .b_req_addr (b_req_addr),
        .b_rsp_valid (b_rsp_valid), .b_rsp_ready (b_rsp_ready), .b_rsp_rdata (b_rsp_rdata),
        .csb0 (csb0), .web0 (web0), .wmask0 (wmask0), .addr0 (addr0), .din0 (din0),
        .dout0 (dout0), .csb1 (csb1), .addr1 (addr1), .dout1 (dout1)
    );

    // Macro model: pins registered at the rising edge; idle ports output junk.
    always @(posedge clk) begin
        if (!csb0 && !web0) begin
            for (int i = 0; i < NM; i++)
                if (wmask0[i]) macro_mem[addr0][i*8 +: 8] <= din0[i*8 +: 8];
            dout0 <= {$urandom, $urandom};
        end else if (!csb0) begin
            dout0 <= macro_mem[addr0];
        end else begin
            dout0 <= {$urandom, $urandom};
        end
        if (!csb1) dout1 <= macro_mem[addr1];
        else       dout1 <= {$urandom, $urandom};
    end

    task automatic idle_inputs();
        a_req_valid = 1'b0; a_req_we = 1'b0; a_req_wmask = '0;
        a_req_addr = '0; a_req_wdata = '0; b_req_valid = 1'b0; b_req_addr = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        a_rsp_ready = 1'b1; b_rsp_ready = 1'b1;
        a_req_valid = 1'b1; b_req_valid = 1'b1;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        n_checks++; if (a_req_ready !== 1'b0) begin n_fail++; $display("FAIL reset_a_ready: got %b want 0", a_req_ready); end
        n_checks++; if (b_req_ready !== 1'b0) begin n_fail++; $display("FAIL reset_b_ready: got %b want 0", b_req_ready); end
        n_checks++; if (csb0 !== 1'b1) begin n_fail++; $display("FAIL reset_csb0: got %b want 1", csb0); end
        n_checks++; if (csb1 !== 1'b1) begin n_fail++; $display("FAIL reset_csb1: got %b want 1", csb1); end
        n_checks++; if (web0 !== 1'b1) begin n_fail++; $display("FAIL reset_web0: got %b want 1", web0); end
        n_checks++; if (a_rsp_valid !== 1'b0 || b_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b%b want 00", a_rsp_valid, b_rsp_valid); end
        n_checks++; if (a_rsp_rdata !== '0 || b_rsp_rdata !== '0) begin n_fail++; $display("FAIL reset_rdata: got %h %h want 0", a_rsp_rdata, b_rsp_rdata); end
        @(negedge clk);
        idle_inputs();
        rst = 1'b0;
    endtask

    task automatic test_write_read();
        @(negedge clk);
        a_req_valid = 1'b1; a_req_we = 1'b1; a_req_wmask = 8'hFF;
        a_req_addr = 8'h10; a_req_wdata = 64'h0123456789ABCDEF;
        #1;
        n_checks++; if (a_req_ready !== 1'b1 || csb0 !== 1'b0 || web0 !== 1'b0) begin n_fail++; $display("FAIL wr_pins: got rdy=%b csb0=%b web0=%b want 1 0 0", a_req_ready, csb0, web0); end
        ref_mem[8'h10] = 64'h0123456789ABCDEF;
        @(negedge clk);
        a_req_we = 1'b0;
        #1;
        n_checks++; if (csb0 !== 1'b0 || web0 !== 1'b1) begin n_fail++; $display("FAIL rd_pins: got csb0=%b web0=%b want 0 1", csb0, web0); end
        @(negedge clk);
        idle_inputs();
        #1;
        n_checks++; if (a_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rd_early_valid: got %b want 0", a_rsp_valid); end
        @(negedge clk);
        #1;
        n_checks++; if (a_rsp_valid !== 1'b1) begin n_fail++; $display("FAIL rd_latency_valid: got %b want 1", a_rsp_valid); end
        n_checks++; if (a_rsp_rdata !== 64'h0123456789ABCDEF) begin n_fail++; $display("FAIL rd_data: got %h want 0123456789abcdef", a_rsp_rdata); end
        @(negedge clk);
        #1;
        n_checks++; if (a_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rd_pop: got %b want 0", a_rsp_valid); end
    endtask

    task automatic test_masked_write();
        @(negedge clk);
        a_req_valid = 1'b1; a_req_we = 1'b1; a_req_wmask = 8'h01;
        a_req_addr = 8'h10; a_req_wdata = 64'h00000000000000FF;
        ref_mem[8'h10] = 64'h0123456789ABCDFF;
        @(negedge clk);
        idle_inputs();
        b_req_valid = 1'b1; b_req_addr = 8'h10;
        #1;
        n_checks++; if (b_req_ready !== 1'b1 || csb1 !== 1'b0 || addr1 !== 8'h10) begin n_fail++; $display("FAIL mask_b_issue: got rdy=%b csb1=%b addr1=%h want 1 0 10", b_req_ready, csb1, addr1); end
        @(negedge clk);
        idle_inputs();
        @(negedge clk);
        #1;
        n_checks++; if (b_rsp_valid !== 1'b1 || b_rsp_rdata !== 64'h0123456789ABCDFF) begin n_fail++; $display("FAIL mask_b_data: got v=%b %h want 1 0123456789abcdff", b_rsp_valid, b_rsp_rdata); end
        @(negedge clk);
    endtask

    task automatic test_collision();
        @(negedge clk);
        a_req_valid = 1'b1; a_req_we = 1'b1; a_req_wmask = 8'hFF;
        a_req_addr = 8'h20; a_req_wdata = 64'hDEADBEEFCAFEF00D;
        b_req_valid = 1'b1; b_req_addr = 8'h20;
        ref_mem[8'h20] = 64'hDEADBEEFCAFEF00D;
        #1;
        n_checks++; if (b_req_ready !== 1'b0 || csb1 !== 1'b1) begin n_fail++; $display("FAIL coll_stall: got rdy=%b csb1=%b want 0 1", b_req_ready, csb1); end
        n_checks++; if (csb0 !== 1'b0) begin n_fail++; $display("FAIL coll_a_write: got csb0=%b want 0", csb0); end
        @(negedge clk);
        a_req_valid = 1'b0;
        #1;
        n_checks++; if (b_req_ready !== 1'b1 || csb1 !== 1'b0) begin n_fail++; $display("FAIL coll_release: got rdy=%b csb1=%b want 1 0", b_req_ready, csb1); end
        @(negedge clk);
        idle_inputs();
        @(negedge clk);
        #1;
        n_checks++; if (b_rsp_valid !== 1'b1 || b_rsp_rdata !== 64'hDEADBEEFCAFEF00D) begin n_fail++; $display("FAIL coll_data: got v=%b %h want 1 deadbeefcafef00d", b_rsp_valid, b_rsp_rdata); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        a_rsp_ready = 1'b0;
        a_req_valid = 1'b1; a_req_we = 1'b0; a_req_addr = 8'h10;
        #1;
        n_checks++; if (a_req_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_rdy1: got %b want 1", a_req_ready); end
        @(negedge clk);
        a_req_addr = 8'h20;
        #1;
        n_checks++; if (a_req_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_rdy2: got %b want 1", a_req_ready); end
        @(negedge clk);
        a_req_addr = 8'h10;
        #1;
        n_checks++; if (a_req_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_rdy3_full: got %b want 0", a_req_ready); end
        n_checks++; if (a_rsp_valid !== 1'b1 || a_rsp_rdata !== 64'h0123456789ABCDFF) begin n_fail++; $display("FAIL b2b_first: got v=%b %h want 1 0123456789abcdff", a_rsp_valid, a_rsp_rdata); end
        @(negedge clk);
        #1;
        n_checks++; if (a_req_ready !== 1'b0 || a_rsp_rdata !== 64'h0123456789ABCDFF) begin n_fail++; $display("FAIL b2b_hold: got rdy=%b %h want 0 0123456789abcdff", a_req_ready, a_rsp_rdata); end
        a_rsp_ready = 1'b1;
        #1;
        n_checks++; if (a_req_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_pop_no_credit: got %b want 0", a_req_ready); end
        @(negedge clk);
        #1;
        n_checks++; if (a_req_ready !== 1'b1 || a_rsp_rdata !== 64'hDEADBEEFCAFEF00D) begin n_fail++; $display("FAIL b2b_second: got rdy=%b %h want 1 deadbeefcafef00d", a_req_ready, a_rsp_rdata); end
        @(negedge clk);
        idle_inputs();
        #1;
        n_checks++; if (a_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_gap: got %b want 0", a_rsp_valid); end
        @(negedge clk);
        #1;
        n_checks++; if (a_rsp_valid !== 1'b1 || a_rsp_rdata !== 64'h0123456789ABCDFF) begin n_fail++; $display("FAIL b2b_third: got v=%b %h want 1 0123456789abcdff", a_rsp_valid, a_rsp_rdata); end
        @(negedge clk);
        #1;
        n_checks++; if (a_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drained: got %b want 0", a_rsp_valid); end
    endtask

    task automatic test_reset_inflight();
        @(negedge clk);
        b_req_valid = 1'b1; b_req_addr = 8'h10;
        @(posedge clk);
        #2;
        b_req_valid = 1'b0;
        a_req_valid = 1'b1; a_req_we = 1'b0; a_req_addr = 8'h20;
        rst = 1'b1;
        #1;
        n_checks++; if (csb0 !== 1'b1 || csb1 !== 1'b1) begin n_fail++; $display("FAIL rstfl_csb: got %b%b want 11", csb0, csb1); end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            #1;
            n_checks++; if (b_rsp_valid !== 1'b0 || csb0 !== 1'b1 || csb1 !== 1'b1) begin n_fail++; $display("FAIL rstfl_hold: got bv=%b csb=%b%b want 0 11", b_rsp_valid, csb0, csb1); end
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_checks++; if (a_req_ready !== 1'b1) begin n_fail++; $display("FAIL rstfl_first_accept: got %b want 1", a_req_ready); end
        @(negedge clk);
        idle_inputs();
        @(negedge clk);
        #1;
        n_checks++; if (a_rsp_valid !== 1'b1 || a_rsp_rdata !== 64'hDEADBEEFCAFEF00D) begin n_fail++; $display("FAIL rstfl_a_data: got v=%b %h want 1 deadbeefcafef00d", a_rsp_valid, a_rsp_rdata); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            n_checks++; if (b_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rstfl_stale_b: got %b want 0", b_rsp_valid); end
        end
    endtask

    task automatic test_random();
        rsp_t qa[$];
        rsp_t qb[$];
        rsp_t e;
        logic exp_ar, exp_br, a_hs, b_hs, exp_av, exp_bv;
        for (int k = 0; k < 10010; k++) begin
            @(negedge clk);
            if (k < 10000) begin
                a_req_valid = ($urandom_range(0, 3) != 0);
                a_req_we    = ($urandom_range(0, 1) != 0);
                a_req_wmask = NM'($urandom);
                a_req_addr  = AW'($urandom_range(0, 15));
                a_req_wdata = {$urandom, $urandom};
                b_req_valid = ($urandom_range(0, 3) != 0);
                b_req_addr  = AW'($urandom_range(0, 15));
                a_rsp_ready = ($urandom_range(0, 3) != 0);
                b_rsp_ready = ($urandom_range(0, 3) != 0);
            end else begin
                idle_inputs();
                a_rsp_ready = 1'b1; b_rsp_ready = 1'b1;
            end
            #1;
            exp_ar = a_req_we ? 1'b1 : (qa.size() < DEPTH);
            n_checks++; if (a_req_ready !== exp_ar) begin n_fail++; $display("FAIL rnd_a_ready @%0d: got %b want %b", k, a_req_ready, exp_ar); end
            a_hs = a_req_valid && exp_ar;
            exp_br = (qb.size() < DEPTH) && !(a_hs && a_req_we && (a_req_addr == b_req_addr));
            n_checks++; if (b_req_ready !== exp_br) begin n_fail++; $display("FAIL rnd_b_ready @%0d: got %b want %b", k, b_req_ready, exp_br); end
            b_hs = b_req_valid && exp_br;
            n_checks++; if (csb0 !== !a_hs || csb1 !== !b_hs) begin n_fail++; $display("FAIL rnd_csb @%0d: got %b%b want %b%b", k, csb0, csb1, !a_hs, !b_hs); end
            exp_av = (qa.size() > 0) && (qa[0].cyc + 2 <= k);
            exp_bv = (qb.size() > 0) && (qb[0].cyc + 2 <= k);
            n_checks++; if (a_rsp_valid !== exp_av) begin n_fail++; $display("FAIL rnd_a_valid @%0d: got %b want %b", k, a_rsp_valid, exp_av); end
            n_checks++; if (b_rsp_valid !== exp_bv) begin n_fail++; $display("FAIL rnd_b_valid @%0d: got %b want %b", k, b_rsp_valid, exp_bv); end
            if (exp_av && a_rsp_ready) begin
                n_checks++; if (a_rsp_rdata !== qa[0].data) begin n_fail++; $display("FAIL rnd_a_rdata @%0d: got %h want %h", k, a_rsp_rdata, qa[0].data); end
                void'(qa.pop_front());
            end
            if (exp_bv && b_rsp_ready) begin
                n_checks++; if (b_rsp_rdata !== qb[0].data) begin n_fail++; $display("FAIL rnd_b_rdata @%0d: got %h want %h", k, b_rsp_rdata, qb[0].data); end
                void'(qb.pop_front());
            end
            if (b_hs) begin
                e.data = ref_mem[b_req_addr]; e.cyc = k; qb.push_back(e);
            end
            if (a_hs && !a_req_we) begin
                e.data = ref_mem[a_req_addr]; e.cyc = k; qa.push_back(e);
            end
            if (a_hs && a_req_we) begin
                for (int i = 0; i < NM; i++)
                    if (a_req_wmask[i]) ref_mem[a_req_addr][i*8 +: 8] = a_req_wdata[i*8 +: 8];
            end
        end
        n_checks++; if (qa.size() != 0 || qb.size() != 0) begin n_fail++; $display("FAIL rnd_lost_rsp: got %0d/%0d outstanding want 0/0", qa.size(), qb.size()); end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            macro_mem[i] <= '0;
            ref_mem[i] = '0;
        end
        idle_inputs();
        a_rsp_ready = 1'b1;
        b_rsp_ready = 1'b1;
        test_reset();
        test_write_read();
        test_masked_write();
        test_collision();
        test_back_to_back();
        test_reset_inflight();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/sram_1rw1r_ctrl.md
Name: sram_1rw1r_ctrl

Overview:
- Host-side controller that drives both ports of a sky130_sram_1rw1r_64x256_8 macro: port 0 (RW) and port 1 (R).
- Converts two valid/ready request channels (A: read/write, B: read-only) into macro pin activity: csb, web, wmask, addr and din.
- Captures read data into per-channel response FIFOs with valid/ready output.
- Sits between core logic and the macro; all macro pins are driven from this block.

Parameters:
- DATA_WIDTH, 64, data word width.
- ADDR_WIDTH, 8, word address width.
- NUM_WMASKS, 8, byte-lane write-mask width; DATA_WIDTH/NUM_WMASKS = 8.
- RSP_DEPTH, 2, response FIFO entries per channel (power of two, ≥2).

Ports:
- clk  in  1  single clock; also feeds macro clk0 and clk1 at top level.
- rst  in  1  asynchronous active-high reset.
- a_req_valid  in  1  channel A request valid.
- a_req_ready  out  1  channel A request accept.
- a_req_we  in  1  1 = write, 0 = read.
- a_req_wmask  in  NUM_WMASKS  byte enables for a write.
- a_req_addr  in  ADDR_WIDTH  word address.
- a_req_wdata  in  DATA_WIDTH  write data.
- a_rsp_valid  out  1  channel A read data valid.
- a_rsp_ready  in  1  channel A response accept.
- a_rsp_rdata  out  DATA_WIDTH  channel A read data.
- b_req_valid  in  1  channel B read request valid.
- b_req_ready  out  1  channel B request accept.
- b_req_addr  in  ADDR_WIDTH  read address.
- b_rsp_valid  out  1  channel B read data valid.
- b_rsp_ready  in  1  channel B response accept.
- b_rsp_rdata  out  DATA_WIDTH  channel B read data.
- csb0  out  1  macro port 0 chip select, active low.
- web0  out  1  macro port 0 write enable, active low.
- wmask0  out  NUM_WMASKS  macro port 0 byte mask.
- addr0  out  ADDR_WIDTH  macro port 0 address.
- din0  out  DATA_WIDTH  macro port 0 write data.
- dout0  in  DATA_WIDTH  macro port 0 read data.
- csb1  out  1  macro port 1 chip select, active low.
- addr1  out  ADDR_WIDTH  macro port 1 address.
- dout1  in  DATA_WIDTH  macro port 1 read data.

Behaviour:

Macro pin drive:
- Macro pins are driven combinationally from the request channels; the macro registers them at the rising edge.
- A handshake (valid && ready high at rising edge E0) is the issue edge for that request.
- csb0 = !(a_req_valid && a_req_ready).
- web0 = !a_req_we. addr0, wmask0 and din0 pass straight from the A request.
- csb1 = !(b_req_valid && b_req_ready). addr1 = b_req_addr.
- While rst is high, csb0 = csb1 = 1 and web0 = 1.

Read latency and capture:
- For a read issued at E0, macro data is valid before E1.
- The controller captures dout0/dout1 at E1 into that channel's FIFO; rsp_valid rises after E1.
- Fixed latency: 1 cycle from issue to rsp_valid, with the FIFO empty and rsp_ready high.
- One-bit inflight flag per channel is set at read issue and cleared at E1 capture.

Channel A ready:
- Write: a_req_ready = 1; writes produce no response.
- Read: a_req_ready = (fifo_count + inflight) < RSP_DEPTH. A FIFO pop in the same cycle does not count toward space.
- ready depends on a_req_we; this is allowed, and valid may not depend on ready.

Channel B ready:
- b_req_ready = credit available (same rule as A), AND NOT (A write issuing this cycle with a_req_addr == b_req_addr).
- This collision stall lasts exactly one cycle. On the next cycle, B reads the newly written data (byte-merged per wmask).

Response FIFOs:
- Depth RSP_DEPTH, first-word fall-through.
- Push and pop in the same cycle: count unchanged, order preserved.
- rsp_rdata holds its value while rsp_valid && !rsp_ready.

Reset (async):
- FIFOs emptied; a_rsp_valid = b_rsp_valid = 0; inflight flags cleared.
- rsp_rdata = 0; both req_ready = 0 while rst is high.
- A read in flight when reset asserts is discarded; no response is produced after reset release.
- After release, reads are accepted on the first rising edge.

Channel relationship:
- A and B are fully independent apart from the collision rule.
- No ordering guarantee between A and B responses.

Test Plan:
- Reset, then A write addr 0x10, wmask 0xFF, data 0x0123456789ABCDEF; next cycle A read 0x10 → a_rsp_valid 1 cycle after issue, a_rsp_rdata 0x0123456789ABCDEF.
- A write 0x10 wmask 0x01 data 0xFF, then B read 0x10 → b_rsp_rdata 0x0123456789ABCDFF.
- Same cycle: A write 0x20 and B read 0x20 → b_req_ready 0 that cycle, csb1 high. B issues the following cycle and returns the new data.
- Hold a_rsp_ready low, issue 3 back-to-back A reads → first 2 accepted, a_req_ready 0 on the third. Raise a_rsp_ready → responses in order, third read then accepted.
- Issue B read, assert rst before capture edge → b_rsp_valid stays 0, csb0/csb1 stay 1 during reset, no stale response after release.
- Random mixed traffic on A/B against a byte-masked scoreboard memory for 10k cycles → all rdata match, no response lost or duplicated.
